// File: rtl/vga_trace_display.sv
// Captures 160-column trace sweeps into a back buffer, swaps them to a front buffer at vsync, draws them on 640x480@60.
// Latency: write-to-buffer 1 clk; hs/vs/rgb registered 1 clk after raster position; frame_swap 1 clk after swap point.
// Backpressure: none; each sample is accepted or dropped in the cycle it is presented.
module vga_trace_display (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  CounterX,
  input  logic [7:0]  CounterY,
  input  logic [11:0] color,
  input  logic        lock,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_swap
);

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_TOTAL  = 10'd800;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_TOTAL  = 10'd525;
  localparam logic [7:0] LAST_COL = 8'd159;
  localparam logic [7:0] MAX_ROW  = 8'd239;

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [7:0]  expected_x;
  logic [7:0]  exp_x_nxt;
  logic        back_full;
  logic [159:0] back_valid;
  logic [159:0] front_valid;
  // Each entry holds {y[7:0], color[11:0]}; valid bits live in separate vectors so they can be reset.
  logic [19:0] back_dat  [160];
  logic [19:0] front_dat [160];

  logic        swap_point;
  logic        do_swap;
  logic        wr_en;
  logic        active;
  logic [7:0]  rd_col;
  logic [19:0] rd_dat;
  logic [7:0]  clip_y;
  logic        lit;

  // Swap and sample-accept decisions, plus next expected column.
  always_comb begin
    swap_point = (hcount == 10'd0) && (vcount == V_SYNC_S);
    do_swap    = swap_point && back_full;
    // A column-0 sample on a sequence break starts a new sweep, so it is accepted too.
    wr_en      = lock && (CounterX <= LAST_COL) &&
                 ((CounterX == expected_x) || (CounterX == 8'd0));
    exp_x_nxt  = expected_x;
    if (!lock) begin
      exp_x_nxt = 8'd0;
    end else if (CounterX <= LAST_COL) begin
      if (wr_en) begin
        exp_x_nxt = (CounterX == LAST_COL) ? 8'd0 : CounterX + 8'd1;
      end else begin
        exp_x_nxt = 8'd0;
      end
    end
  end

  // Free-running 800x525 raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (hcount == H_TOTAL - 10'd1) begin
      hcount <= 10'd0;
      vcount <= (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  // Sweep tracking, valid bits and the back_full flag; a sweep completing in the swap cycle keeps back_full set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_x  <= 8'd0;
      back_full   <= 1'b0;
      back_valid  <= '0;
      front_valid <= '0;
    end else begin
      expected_x <= exp_x_nxt;
      back_full  <= (back_full && !do_swap) || (wr_en && (CounterX == LAST_COL));
      if (do_swap) begin
        front_valid <= back_valid;
      end
      if (wr_en) begin
        back_valid[CounterX] <= 1'b1;
      end
    end
  end

  // Buffer payloads; contents are don't-care until their valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      back_dat[CounterX] <= {CounterY, color};
    end
    if (do_swap) begin
      front_dat <= back_dat;
    end
  end

  // Pixel decision from the current raster position and the front buffer.
  always_comb begin
    active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
    rd_col = active ? hcount[9:2] : 8'd0;
    rd_dat = front_dat[rd_col];
    clip_y = (rd_dat[19:12] > MAX_ROW) ? MAX_ROW : rd_dat[19:12];
    lit    = active && front_valid[rd_col] && (vcount[8:1] == MAX_ROW - clip_y);
  end

  // Registered VGA outputs and swap pulse, all one clock behind the raster.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_hs     <= 1'b1;
      vga_vs     <= 1'b1;
      vga_r      <= 4'd0;
      vga_g      <= 4'd0;
      vga_b      <= 4'd0;
      frame_swap <= 1'b0;
    end else begin
      vga_hs     <= !((hcount >= H_SYNC_S) && (hcount < H_SYNC_E));
      vga_vs     <= !((vcount >= V_SYNC_S) && (vcount < V_SYNC_E));
      vga_r      <= lit ? rd_dat[11:8] : 4'd0;
      vga_g      <= lit ? rd_dat[7:4]  : 4'd0;
      vga_b      <= lit ? rd_dat[3:0]  : 4'd0;
      frame_swap <= do_swap;
    end
  end

endmodule

// File: tb/tb_vga_trace_display.sv
// Scoreboard bench for vga_trace_display: a raster/buffer reference model queues the expected output of every clock,
// a monitor pops and compares per scanline, and separate checks cover sync widths/periods, reset and swap counts.
module tb_vga_trace_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  CounterX = 8'd0;
  logic [7:0]  CounterY = 8'd0;
  logic [11:0] color = 12'd0;
  logic        lock = 1'b0;
  logic        vga_hs, vga_vs, frame_swap;
  logic [3:0]  vga_r, vga_g, vga_b;

  always #20 clk = ~clk;

  vga_trace_display dut (
    .clk(clk), .rst(rst), .CounterX(CounterX), .CounterY(CounterY), .color(color), .lock(lock),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_swap(frame_swap)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run = 0;

  typedef struct { bit hs; bit vs; int rgb; bit sw; int hc; int vc; int frm; } exp_t;
  exp_t sb[$];

  // Reference model state: raster position, buffers as plain arrays, sweep progress.
  int hc, vc, frm, exp_x;
  bit bfull;
  bit bv[160];
  bit fv[160];
  int by[160], bc[160], fy[160], fc[160];

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    hc = 0; vc = 0; frm = 0; exp_x = 0; bfull = 0;
    for (int i = 0; i < 160; i++) begin
      bv[i] = 0; fv[i] = 0;
    end
  endtask

  // One clock of the reference: queue the output this position produces, then apply swap, write and raster advance.
  task automatic model_step();
    exp_t e;
    int col, row, v, x;
    e.hs = !(hc >= 656 && hc <= 751);
    e.vs = !(vc >= 490 && vc <= 491);
    e.rgb = 0;
    if (hc < 640 && vc < 480) begin
      col = hc / 4;
      row = vc / 2;
      v = (fy[col] > 239) ? 239 : fy[col];
      if (fv[col] && row == 239 - v) e.rgb = fc[col];
    end
    e.sw = (hc == 0 && vc == 490 && bfull);
    e.hc = hc; e.vc = vc; e.frm = frm;
    sb.push_back(e);
    if (e.sw) begin
      for (int i = 0; i < 160; i++) begin
        fv[i] = bv[i]; fy[i] = by[i]; fc[i] = bc[i];
      end
      bfull = 0;
    end
    x = int'(CounterX);
    if (!lock) exp_x = 0;
    else if (x <= 159) begin
      if (x == exp_x || x == 0) begin
        bv[x] = 1; by[x] = int'(CounterY); bc[x] = int'(color);
        if (x == 159) begin
          bfull = 1; exp_x = 0;
        end else exp_x = x + 1;
      end else exp_x = 0;
    end
    hc++;
    if (hc == 800) begin
      hc = 0; vc++;
      if (vc == 525) begin
        vc = 0; frm++;
      end
    end
  endtask

  always @(negedge clk) if (run) model_step();

  // Monitor: sync timing measurements, swap pulse count and per-line scoreboard comparison.
  int hs_low, hs_since, vs_low, vs_since, swap_cnt;
  bit hs_seen, vs_seen, prev_hs, prev_vs, line_bad;
  exp_t bad_e;
  int bad_act_rgb;
  bit bad_act_hs, bad_act_vs, bad_act_sw;

  always begin
    exp_t e;
    @(posedge clk);
    #2;
    if (!run) begin
      sb.delete();
      hs_low = 0; hs_since = 0; hs_seen = 0; prev_hs = 1;
      vs_low = 0; vs_since = 0; vs_seen = 0; prev_vs = 1;
      line_bad = 0;
    end else begin
      if (frame_swap) swap_cnt++;
      if (hs_seen) hs_since++;
      if (!vga_hs && prev_hs) begin
        if (hs_seen) check("hs_period", hs_since, 800);
        hs_seen = 1; hs_since = 0;
      end
      if (!vga_hs) hs_low++;
      else if (hs_low > 0) begin
        check("hs_low_width", hs_low, 96); hs_low = 0;
      end
      prev_hs = vga_hs;
      if (vs_seen) vs_since++;
      if (!vga_vs && prev_vs) begin
        if (vs_seen) check("vs_period", vs_since, 420000);
        vs_seen = 1; vs_since = 0;
      end
      if (!vga_vs) vs_low++;
      else if (vs_low > 0) begin
        check("vs_low_width", vs_low, 1600); vs_low = 0;
      end
      prev_vs = vga_vs;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!line_bad && (vga_hs != e.hs || vga_vs != e.vs || frame_swap != e.sw ||
                          int'({vga_r, vga_g, vga_b}) != e.rgb)) begin
          line_bad = 1; bad_e = e;
          bad_act_hs = vga_hs; bad_act_vs = vga_vs; bad_act_sw = frame_swap;
          bad_act_rgb = int'({vga_r, vga_g, vga_b});
        end
        if (e.hc == 799) begin
          n_tests++;
          if (line_bad) begin
            n_fail++;
            $display("FAIL pixel f%0d v%0d h%0d: got hs=%0d vs=%0d rgb=%03h swap=%0d, expected hs=%0d vs=%0d rgb=%03h swap=%0d",
                     bad_e.frm, bad_e.vc, bad_e.hc, bad_act_hs, bad_act_vs, bad_act_rgb, bad_act_sw,
                     bad_e.hs, bad_e.vs, bad_e.rgb, bad_e.sw);
          end
          line_bad = 0;
        end
      end
    end
  end

  task automatic wait_pos(input int f, input int v, input int h);
    int n = 0;
    while (!(frm == f && vc == v && hc == h)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 500000) begin
        n_tests++; n_fail++;
        $display("FAIL wait_timeout: got no raster position f%0d v%0d h%0d, expected it within 500000 clocks", f, v, h);
        return;
      end
    end
  endtask

  task automatic drive(input int x, input int y, input int c, input bit l);
    CounterX = 8'(x); CounterY = 8'(y); color = 12'(c); lock = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CounterX = 8'd0; CounterY = 8'd0; color = 12'd0; lock = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hs"}, int'(vga_hs), 1);
    check({tag, "_vs"}, int'(vga_vs), 1);
    check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
    check({tag, "_swap"}, int'(frame_swap), 0);
  endtask

  initial begin
    swap_cnt = 0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0; run = 1;

    // Reset asserted mid-line while hsync is low; outputs must drop back asynchronously.
    wait_pos(0, 1, 700);
    check("pre_reset_hs", int'(vga_hs), 0);
    rst = 1'b1; run = 0;
    #1;
    check_reset_outputs("midline");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; run = 1;

    // Full sweep with clipping columns, out-of-range gap samples scattered through it.
    wait_pos(0, 100, 0);
    for (int x = 0; x < 160; x++) begin
      repeat ($urandom_range(0, 2)) drive($urandom_range(160, 255), $urandom_range(0, 255), $urandom_range(0, 4095), 1);
      drive(x, (x == 10) ? 250 : ((x == 11) ? 0 : 100), 12'hF00, 1);
    end
    idle();
    wait_pos(1, 0, 0);
    check("swaps_after_frame0", swap_cnt, 1);

    // Incomplete sweep: lock drops at column 80.
    wait_pos(1, 100, 0);
    for (int x = 0; x < 80; x++) drive(x, $urandom_range(0, 255), $urandom_range(0, 4095), 1);
    drive(80, $urandom_range(0, 255), $urandom_range(0, 4095), 0);
    idle();

    // Sequence break: 0..50 then 60..159 must not complete a sweep.
    wait_pos(1, 200, 0);
    for (int x = 0; x <= 50; x++) drive(x, $urandom_range(0, 255), $urandom_range(0, 4095), 1);
    for (int x = 60; x < 160; x++) drive(x, $urandom_range(0, 255), $urandom_range(0, 4095), 1);
    idle();

    // Boundary race: column 159 lands exactly in the swap-point cycle.
    wait_pos(1, 489, 641);
    for (int x = 0; x < 160; x++) drive(x, $urandom_range(200, 255), $urandom_range(0, 4095), 1);
    idle();
    wait_pos(2, 0, 0);
    check("swaps_after_frame1", swap_cnt, 1);
    wait_pos(3, 0, 0);
    check("swaps_after_frame2", swap_cnt, 2);
    wait_pos(3, 80, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_trace_display.md
# vga_trace_display

Downstream display stage for the ADC trace path. It consumes the per-cycle sample stream (column index, 8-bit sample value, 12-bit colour, lock) produced by the sweep stage and captures complete 160-column sweeps into a back buffer. At vertical sync it swaps each complete sweep into a front buffer, and it generates 640x480@60 VGA timing that draws the front buffer as a one-pixel-per-row trace on black.

## Interface
Parameters:
- None. Geometry is fixed: 160 columns, 640x480 raster, 4 pixels per column, 2 lines per row.

Ports:
- clk  in  1  pixel clock, 25.175 MHz; the only clock
- rst  in  1  asynchronous, active-high reset
- CounterX  in  8  sample column index from the sweep stage; 0..159 valid
- CounterY  in  8  sample value (0 = bottom of scale)
- color  in  12  trace colour {R[3:0],G[3:0],B[3:0]} for this sample
- lock  in  1  sweep-stage lock; a sample is written only when lock=1
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- frame_swap  out  1  one-cycle pulse when a buffer swap occurs

## Operation
- Storage: two 160-entry arrays, back and front. Each entry is {valid, y[7:0], color[11:0]}.
- Write side, evaluated every cycle:
  - Sample accepted when lock=1, CounterX<=159 and CounterX==expected_x. Action: back[CounterX] <= {1, CounterY, color}; expected_x increments.
  - Accepting CounterX==159 sets back_full and returns expected_x to 0.
  - lock=1 with CounterX!=expected_x is a sequence break. The sample is discarded and expected_x returns to 0. A CounterX==0 arriving in that same cycle is accepted as a new sweep start, and expected_x becomes 1.
  - lock=0 returns expected_x to 0. back_full is unchanged.
  - CounterX>159 is ignored and does not count as a break.
  - Writes continue while back_full=1. A newer complete sweep overwrites the older one.
- Swap point: hcount==0 and vcount==490, which is the first cycle of vsync.
  - If back_full=1 at the swap point: front <= back (all 160 entries in one cycle), back_full <= 0, frame_swap=1 for one cycle.
  - If back_full=0: no swap and no pulse.
- Display side:
  - col = hcount>>2 (0..159); row = vcount>>1 (0..239).
  - Plotted value v = min(front[col].y, 239). Value 255 draws at row 0.
  - A pixel is lit if it is in the active area, front[col].valid=1 and row == 239-v. A lit pixel outputs front[col].color; every other pixel is 0x000.
- Reset state:
  - hcount=0, vcount=0, expected_x=0, back_full=0.
  - All valid bits in both buffers are 0.
  - vga_hs=1, vga_vs=1, vga_r/g/b=0, frame_swap=0.
  - y and color contents are don't-care.
- Reset mid-frame: all outputs return to reset values immediately and asynchronously. The raster restarts at (0,0) on the first clk after release, and the trace stays blank until the next swap.

## Timing
- Horizontal: 800 clocks per line.
  - Active 0-639, front porch 640-655, sync 656-751 (vga_hs=0 for 96 clocks), back porch 752-799.
- Vertical: 525 lines per frame.
  - Active 0-479, front porch 480-489, sync 490-491 (vga_vs=0 for 2 lines), back porch 492-524.
- Output pipeline: vga_hs, vga_vs and rgb are registered from the current hcount/vcount and front buffer. All three have exactly 1 clock of latency, so they stay mutually aligned.
- frame_swap is asserted in the cycle after the swap-point cycle, aligned with the first low cycle of vga_vs.
- Write-to-buffer latency: 1 clock. back_full becomes visible one clock after the x=159 sample.
  - Consequence: an x=159 sample presented in the swap-point cycle does not cause a swap. It is displayed after the following frame's swap.
- Front buffer changes only at the swap point, so the active area never shows a torn trace.

## Test plan
- Reset and raster:
  - Stimulus: assert rst mid-line, then release.
  - Required: outputs read hs=1, vs=1, rgb=0, frame_swap=0 during reset. After release, hs period is 800 clocks with 96 low. vs is low for 1600 clocks every 420000 clocks.
- Full sweep:
  - Stimulus: lock=1, CounterX stepping 0..159, CounterY=100, color=0xF00, driven before the swap point.
  - Required: frame_swap pulses once. On the next frame, lines 278-279 (row 139) show 0xF00 across pixels 0-639. All other active pixels are 0x000.
- Clipping and column mapping:
  - Stimulus: sweep with y=250 at x=10 and y=0 at x=11, all other entries 100.
  - Required: pixels 40-43 are lit on lines 0-1. Pixels 44-47 are lit on lines 478-479.
- Incomplete sweep:
  - Stimulus: lock drops at x=80, then no further samples.
  - Required: no frame_swap and the previous front image is unchanged. A later sweep from 0..159 restores swapping.
- Sequence break:
  - Stimulus: x jumps 0..50 then 60.
  - Required: the sample at x=60 is discarded, and back_full stays 0 until a fresh sweep 0..159 completes.
- Boundary race:
  - Stimulus: x=159 accepted in the swap-point cycle.
  - Required: no swap in that frame. frame_swap is asserted at the next frame's swap point.
